alu_result_checker: RTL and testbench

ALU_RESULT_CHECKER -- requirements
Module: alu_result_checker

---
 rtl/alu_result_checker.sv | 239 +++++++++++++++++++++++
 tb/tb_alu_result_checker.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_result_checker.sv
// alu_result_checker
// Watches a 32-bit ALU through a valid/ready port and compares each observed
// result and zero flag against a local reference model.
// Stage 1 registers the reference result next to the observed one.
// Stage 2 compares them one edge later and updates the saturating pass/fail
// counters and the sticky error flag.
// The first failing transaction is latched into the ff_* outputs.
// With STOP_ON_FAIL set, the checker parks in HALT after the first mismatch
// until clear or reset.

module alu_result_checker #(
  parameter bit STOP_ON_FAIL = 1'b0,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             chk_valid,
  output logic             chk_ready,
  input  logic [31:0]      SrcA,
  input  logic [31:0]      SrcB,
  input  logic [2:0]       ALUControl,
  input  logic [31:0]      ALUResult,
  input  logic             Zero,
  input  logic             clear,
  output logic [CNT_W-1:0] pass_count,
  output logic [CNT_W-1:0] fail_count,
  output logic             error,
  output logic [CNT_W-1:0] ff_index,
  output logic [2:0]       ff_op,
  output logic [31:0]      ff_expected,
  output logic [31:0]      ff_actual
);

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_e;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_OR   = 3'b011;
  localparam logic [2:0] OP_XOR  = 3'b100;
  localparam logic [2:0] OP_NOR  = 3'b101;
  localparam logic [2:0] OP_SLT  = 3'b110;
  localparam logic [2:0] OP_SLTU = 3'b111;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_e state_q, state_d;

  logic accept;
  logic cmpDiff;
  logic mismatch;
  logic matchNow;
  logic haltNow;

  logic [31:0] expResult;
  logic        expZero;

  logic             s1Valid_q,    s1Valid_d;
  logic [31:0]      s1Expected_q, s1Expected_d;
  logic             s1ExpZero_q,  s1ExpZero_d;
  logic [2:0]       s1Op_q,       s1Op_d;
  logic [31:0]      s1Result_q,   s1Result_d;
  logic             s1Zero_q,     s1Zero_d;
  logic [CNT_W-1:0] s1Index_q,    s1Index_d;

  logic [CNT_W-1:0] idx_q,        idx_d;
  logic [CNT_W-1:0] passCnt_q,    passCnt_d;
  logic [CNT_W-1:0] failCnt_q,    failCnt_d;
  logic             error_q,      error_d;
  logic [CNT_W-1:0] ffIndex_q,    ffIndex_d;
  logic [2:0]       ffOp_q,       ffOp_d;
  logic [31:0]      ffExpected_q, ffExpected_d;
  logic [31:0]      ffActual_q,   ffActual_d;

  // Reference ALU: what the observed ALU should have produced for these operands
  always_comb begin
    expResult = 32'd0;
    case (ALUControl)
      OP_ADD:  expResult = SrcA + SrcB;
      OP_SUB:  expResult = SrcA - SrcB;
      OP_AND:  expResult = SrcA & SrcB;
      OP_OR:   expResult = SrcA | SrcB;
      OP_XOR:  expResult = SrcA ^ SrcB;
      OP_NOR:  expResult = ~(SrcA | SrcB);
      OP_SLT:  expResult = {31'd0, ($signed(SrcA) < $signed(SrcB))};
      OP_SLTU: expResult = {31'd0, (SrcA < SrcB)};
      default: expResult = 32'd0;
    endcase
    expZero = (expResult == 32'd0);
  end

  // Stage-2 compare of the registered reference against the registered observation
  always_comb begin
    cmpDiff  = (s1Result_q != s1Expected_q) || (s1Zero_q != s1ExpZero_q);
    mismatch = s1Valid_q && cmpDiff;
    matchNow = s1Valid_q && !cmpDiff;
    haltNow  = STOP_ON_FAIL && mismatch;
  end

  // FSM next state: clear always returns to RUN, a stopping mismatch parks in HALT
  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = ST_RUN;
    end else begin
      case (state_q)
        ST_RUN:  if (haltNow) state_d = ST_HALT;
        ST_HALT: state_d = ST_HALT;
        default: state_d = ST_RUN;
      endcase
    end
  end

  // FSM outputs: the checker only takes transactions while running
  always_comb begin
    chk_ready = (state_q == ST_RUN);
    accept    = chk_valid && chk_ready;
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Pipeline, counters and first-failure capture; clear overrides everything
  always_comb begin
    s1Valid_d    = 1'b0;
    s1Expected_d = s1Expected_q;
    s1ExpZero_d  = s1ExpZero_q;
    s1Op_d       = s1Op_q;
    s1Result_d   = s1Result_q;
    s1Zero_d     = s1Zero_q;
    s1Index_d    = s1Index_q;
    idx_d        = idx_q;
    passCnt_d    = passCnt_q;
    failCnt_d    = failCnt_q;
    error_d      = error_q;
    ffIndex_d    = ffIndex_q;
    ffOp_d       = ffOp_q;
    ffExpected_d = ffExpected_q;
    ffActual_d   = ffActual_q;

    if (clear) begin
      s1Expected_d = 32'd0;
      s1ExpZero_d  = 1'b0;
      s1Op_d       = 3'd0;
      s1Result_d   = 32'd0;
      s1Zero_d     = 1'b0;
      s1Index_d    = '0;
      idx_d        = '0;
      passCnt_d    = '0;
      failCnt_d    = '0;
      error_d      = 1'b0;
      ffIndex_d    = '0;
      ffOp_d       = 3'd0;
      ffExpected_d = 32'd0;
      ffActual_d   = 32'd0;
    end else begin
      if (accept) begin
        // A transaction taken on the same edge that halts the checker is dropped
        s1Valid_d    = !haltNow;
        s1Expected_d = expResult;
        s1ExpZero_d  = expZero;
        s1Op_d       = ALUControl;
        s1Result_d   = ALUResult;
        s1Zero_d     = Zero;
        s1Index_d    = idx_q;
        idx_d        = idx_q + CNT_ONE;
      end

      if (mismatch) begin
        if (failCnt_q != CNT_MAX) failCnt_d = failCnt_q + CNT_ONE;
        if (!error_q) begin
          error_d      = 1'b1;
          ffIndex_d    = s1Index_q;
          ffOp_d       = s1Op_q;
          ffExpected_d = s1Expected_q;
          ffActual_d   = s1Result_q;
        end
      end else if (matchNow) begin
        if (passCnt_q != CNT_MAX) passCnt_d = passCnt_q + CNT_ONE;
      end
    end
  end

  // Pipeline, counter and capture registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1Valid_q    <= 1'b0;
      s1Expected_q <= 32'd0;
      s1ExpZero_q  <= 1'b0;
      s1Op_q       <= 3'd0;
      s1Result_q   <= 32'd0;
      s1Zero_q     <= 1'b0;
      s1Index_q    <= '0;
      idx_q        <= '0;
      passCnt_q    <= '0;
      failCnt_q    <= '0;
      error_q      <= 1'b0;
      ffIndex_q    <= '0;
      ffOp_q       <= 3'd0;
      ffExpected_q <= 32'd0;
      ffActual_q   <= 32'd0;
    end else begin
      s1Valid_q    <= s1Valid_d;
      s1Expected_q <= s1Expected_d;
      s1ExpZero_q  <= s1ExpZero_d;
      s1Op_q       <= s1Op_d;
      s1Result_q   <= s1Result_d;
      s1Zero_q     <= s1Zero_d;
      s1Index_q    <= s1Index_d;
      idx_q        <= idx_d;
      passCnt_q    <= passCnt_d;
      failCnt_q    <= failCnt_d;
      error_q      <= error_d;
      ffIndex_q    <= ffIndex_d;
      ffOp_q       <= ffOp_d;
      ffExpected_q <= ffExpected_d;
      ffActual_q   <= ffActual_d;
    end
  end

  assign pass_count  = passCnt_q;
  assign fail_count  = failCnt_q;
  assign error       = error_q;
  assign ff_index    = ffIndex_q;
  assign ff_op       = ffOp_q;
  assign ff_expected = ffExpected_q;
  assign ff_actual   = ffActual_q;

endmodule

// File: tb/tb_alu_result_checker.sv
// tb_alu_result_checker
// Three checker instances share one stimulus bus:
//   u_dut0 has the default parameters.
//   u_dut1 stops on the first failure.
//   u_dut2 uses 4-bit counters.
// Each directed transaction pushes its hand-computed counter state into a
// queue, and a monitor pops and compares that state when the counters
// should reflect it.

module tb_alu_result_checker;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_OR   = 3'b011;
  localparam logic [2:0] OP_XOR  = 3'b100;
  localparam logic [2:0] OP_NOR  = 3'b101;
  localparam logic [2:0] OP_SLT  = 3'b110;
  localparam logic [2:0] OP_SLTU = 3'b111;

  typedef struct packed {
    logic [15:0] passExp;
    logic [15:0] failExp;
    logic        errExp;
    logic        readyExp;
  } sbEntry_t;

  logic        clk;
  logic        rst_n;
  logic        chkValid;
  logic [31:0] srcA;
  logic [31:0] srcB;
  logic [2:0]  aluControl;
  logic [31:0] aluResult;
  logic        zero;
  logic        clear;

  logic        ready0, error0;
  logic [15:0] pass0, fail0, ffIndex0;
  logic [2:0]  ffOp0;
  logic [31:0] ffExp0, ffAct0;

  logic        ready1, error1;
  logic [15:0] pass1, fail1, ffIndex1;
  logic [2:0]  ffOp1;
  logic [31:0] ffExp1, ffAct1;

  logic        ready2, error2;
  logic [3:0]  pass2, fail2, ffIndex2;
  logic [2:0]  ffOp2;
  logic [31:0] ffExp2, ffAct2;

  logic        monReady, monError;
  logic [15:0] monPass, monFail;

  int sel;
  int checks;
  int errors;
  sbEntry_t sbQ[$];

  alu_result_checker #(.STOP_ON_FAIL(1'b0), .CNT_W(16)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .chk_valid(chkValid), .chk_ready(ready0),
    .SrcA(srcA), .SrcB(srcB), .ALUControl(aluControl), .ALUResult(aluResult),
    .Zero(zero), .clear(clear), .pass_count(pass0), .fail_count(fail0),
    .error(error0), .ff_index(ffIndex0), .ff_op(ffOp0),
    .ff_expected(ffExp0), .ff_actual(ffAct0)
  );

  alu_result_checker #(.STOP_ON_FAIL(1'b1), .CNT_W(16)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .chk_valid(chkValid), .chk_ready(ready1),
    .SrcA(srcA), .SrcB(srcB), .ALUControl(aluControl), .ALUResult(aluResult),
    .Zero(zero), .clear(clear), .pass_count(pass1), .fail_count(fail1),
    .error(error1), .ff_index(ffIndex1), .ff_op(ffOp1),
    .ff_expected(ffExp1), .ff_actual(ffAct1)
  );

  alu_result_checker #(.STOP_ON_FAIL(1'b0), .CNT_W(4)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .chk_valid(chkValid), .chk_ready(ready2),
    .SrcA(srcA), .SrcB(srcB), .ALUControl(aluControl), .ALUResult(aluResult),
    .Zero(zero), .clear(clear), .pass_count(pass2), .fail_count(fail2),
    .error(error2), .ff_index(ffIndex2), .ff_op(ffOp2),
    .ff_expected(ffExp2), .ff_actual(ffAct2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Route the instance under test to the monitor
  always_comb begin
    monReady = ready0;
    monError = error0;
    monPass  = pass0;
    monFail  = fail0;
    case (sel)
      1: begin
        monReady = ready1;
        monError = error1;
        monPass  = pass1;
        monFail  = fail1;
      end
      2: begin
        monReady = ready2;
        monError = error2;
        monPass  = {12'd0, pass2};
        monFail  = {12'd0, fail2};
      end
      default: ;
    endcase
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a,
                               input logic [31:0] b, input logic [31:0] res,
                               input logic z, input logic doPush,
                               input logic [15:0] ePass, input logic [15:0] eFail,
                               input logic eErr, input logic eReady);
    sbEntry_t e;
    aluControl = op;
    srcA       = a;
    srcB       = b;
    aluResult  = res;
    zero       = z;
    chkValid   = 1'b1;
    if (doPush) begin
      e.passExp  = ePass;
      e.failExp  = eFail;
      e.errExp   = eErr;
      e.readyExp = eReady;
      sbQ.push_back(e);
    end
    @(posedge clk);
    #1;
    chkValid = 1'b0;
  endtask

  task automatic idle(input int n);
    chkValid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: an accept seen before edge N is reflected after edge N+1
  initial begin : monitor
    bit d1;
    bit d2;
    sbEntry_t e;
    d1 = 1'b0;
    d2 = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        d1 = 1'b0;
        d2 = 1'b0;
      end else begin
        if (d2) begin
          if (sbQ.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL sb_underflow: got an accept, want none queued");
          end else begin
            e = sbQ.pop_front();
            checkOutput("sb_pass",  32'(monPass),  32'(e.passExp));
            checkOutput("sb_fail",  32'(monFail),  32'(e.failExp));
            checkOutput("sb_error", 32'(monError), 32'(e.errExp));
            checkOutput("sb_ready", 32'(monReady), 32'(e.readyExp));
          end
        end
        d2 = clear ? 1'b0 : d1;
        d1 = clear ? 1'b0 : (chkValid && monReady);
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog: got timeout, want completion");
    $fatal(1, "[TB] timeout");
  end

  initial begin : stimulus
    checks     = 0;
    errors     = 0;
    sel        = 0;
    rst_n      = 1'b1;
    chkValid   = 1'b0;
    srcA       = 32'd0;
    srcB       = 32'd0;
    aluControl = 3'd0;
    aluResult  = 32'd0;
    zero       = 1'b0;
    clear      = 1'b0;

    // Asynchronous reset state, before any clock edge
    #1 rst_n = 1'b0;
    #2;
    checkOutput("rst_pass0",  32'(pass0),    32'd0);
    checkOutput("rst_fail0",  32'(fail0),    32'd0);
    checkOutput("rst_error0", 32'(error0),   32'd0);
    checkOutput("rst_ready0", 32'(ready0),   32'd1);
    checkOutput("rst_ffidx0", 32'(ffIndex0), 32'd0);
    checkOutput("rst_ready1", 32'(ready1),   32'd1);
    checkOutput("rst_pass2",  32'(pass2),    32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Basic add/sub, accept indices 0 and 1
    applyStimulus(OP_ADD, 32'd25, 32'd100, 32'd125, 1'b0, 1'b1, 16'd1, 16'd0, 1'b0, 1'b1);
    applyStimulus(OP_SUB, 32'd333, 32'd1024, 32'hFFFF_FD4D, 1'b0, 1'b1, 16'd2, 16'd0, 1'b0, 1'b1);
    idle(3);
    checkOutput("addsub_pass",  32'(pass0),  32'd2);
    checkOutput("addsub_fail",  32'(fail0),  32'd0);
    checkOutput("addsub_error", 32'(error0), 32'd0);

    // Index 2 passes, index 3 fails only on the zero flag
    applyStimulus(OP_OR,  32'h0000_00F0, 32'h0000_0F00, 32'h0000_0FF0, 1'b0, 1'b1, 16'd3, 16'd0, 1'b0, 1'b1);
    applyStimulus(OP_AND, 32'h0000_F0F0, 32'h0000_0F0F, 32'h0, 1'b0, 1'b1, 16'd3, 16'd1, 1'b1, 1'b1);
    applyStimulus(OP_XOR, 32'h0000_FFFF, 32'h0000_FFFF, 32'h0, 1'b1, 1'b1, 16'd4, 16'd1, 1'b1, 1'b1);
    applyStimulus(OP_ADD, 32'hFFFF_FFFF, 32'd1, 32'h0, 1'b1, 1'b1, 16'd5, 16'd1, 1'b1, 1'b1);
    idle(3);
    checkOutput("ff_index", 32'(ffIndex0), 32'd3);
    checkOutput("ff_op",    32'(ffOp0),    32'(OP_AND));
    checkOutput("ff_exp",   ffExp0,        32'd0);
    checkOutput("ff_act",   ffAct0,        32'd0);
    checkOutput("idle_pass_hold", 32'(pass0), 32'd5);

    // Logic and set-less-than ops, then two later failures
    applyStimulus(OP_NOR,  32'h2222, 32'h2222, 32'hFFFF_DDDD, 1'b0, 1'b1, 16'd6, 16'd1, 1'b1, 1'b1);
    applyStimulus(OP_SLT,  32'hF345, 32'h7354, 32'd0, 1'b1, 1'b1, 16'd7, 16'd1, 1'b1, 1'b1);
    applyStimulus(OP_SLTU, 32'hF123, 32'h7811, 32'd0, 1'b1, 1'b1, 16'd8, 16'd1, 1'b1, 1'b1);
    applyStimulus(OP_SLT,  32'h8000_0000, 32'd1, 32'd1, 1'b0, 1'b1, 16'd9, 16'd1, 1'b1, 1'b1);
    applyStimulus(OP_SLTU, 32'h8000_0000, 32'd1, 32'd1, 1'b0, 1'b1, 16'd9, 16'd2, 1'b1, 1'b1);
    applyStimulus(OP_SUB,  32'd5, 32'd3, 32'd3, 1'b0, 1'b1, 16'd9, 16'd3, 1'b1, 1'b1);
    idle(3);
    checkOutput("ff_index_kept", 32'(ffIndex0), 32'd3);
    checkOutput("ff_op_kept",    32'(ffOp0),    32'(OP_AND));
    checkOutput("ff_act_kept",   ffAct0,        32'd0);

    // Clear beats both an in-flight compare and a same-edge accept
    applyStimulus(OP_ADD, 32'd2, 32'd2, 32'd4, 1'b0, 1'b0, 16'd0, 16'd0, 1'b0, 1'b1);
    clear = 1'b1;
    applyStimulus(OP_ADD, 32'd1, 32'd1, 32'd2, 1'b0, 1'b0, 16'd0, 16'd0, 1'b0, 1'b1);
    clear = 1'b0;
    idle(3);
    checkOutput("clr_pass",  32'(pass0),    32'd0);
    checkOutput("clr_fail",  32'(fail0),    32'd0);
    checkOutput("clr_error", 32'(error0),   32'd0);
    checkOutput("clr_ffidx", 32'(ffIndex0), 32'd0);
    checkOutput("clr_ffop",  32'(ffOp0),    32'd0);
    checkOutput("clr_ready1", 32'(ready1),  32'd1);

    // Stop-on-fail: #2 fails, #3 is discarded, #4 is refused
    sel = 1;
    applyStimulus(OP_ADD, 32'd7,  32'd8, 32'd15, 1'b0, 1'b1, 16'd1, 16'd0, 1'b0, 1'b1);
    applyStimulus(OP_SUB, 32'd10, 32'd4, 32'd5,  1'b0, 1'b1, 16'd1, 16'd1, 1'b1, 1'b0);
    applyStimulus(OP_OR,  32'd1,  32'd2, 32'd3,  1'b0, 1'b1, 16'd1, 16'd1, 1'b1, 1'b0);
    applyStimulus(OP_AND, 32'd3,  32'd1, 32'd1,  1'b0, 1'b0, 16'd0, 16'd0, 1'b0, 1'b0);
    idle(3);
    checkOutput("halt_ready", 32'(ready1),   32'd0);
    checkOutput("halt_pass",  32'(pass1),    32'd1);
    checkOutput("halt_fail",  32'(fail1),    32'd1);
    checkOutput("halt_ffidx", 32'(ffIndex1), 32'd1);
    checkOutput("halt_ffexp", ffExp1,        32'd6);
    checkOutput("halt_ffact", ffAct1,        32'd5);
    clear = 1'b1;
    idle(1);
    clear = 1'b0;
    checkOutput("halt_clr_ready", 32'(ready1), 32'd1);
    checkOutput("halt_clr_pass",  32'(pass1),  32'd0);
    checkOutput("halt_clr_fail",  32'(fail1),  32'd0);
    checkOutput("halt_clr_error", 32'(error1), 32'd0);
    idle(2);

    // Narrow counters saturate at 15 while the index wraps
    sel = 2;
    for (int i = 0; i < 20; i++) begin
      applyStimulus(OP_ADD, 32'(i), 32'd1, 32'(i + 1), 1'b0, 1'b1,
                    16'((i + 1) > 15 ? 15 : (i + 1)), 16'd0, 1'b0, 1'b1);
    end
    idle(3);
    checkOutput("sat_pass", 32'(pass2), 32'd15);
    applyStimulus(OP_XOR, 32'd1, 32'd1, 32'd1, 1'b0, 1'b1, 16'd15, 16'd1, 1'b1, 1'b1);
    idle(3);
    checkOutput("wrap_ffidx", 32'(ffIndex2), 32'd4);
    checkOutput("sat_pass_hold", 32'(pass2), 32'd15);

    // Reset mid-stream with a transaction sitting in stage 1
    applyStimulus(OP_ADD, 32'd1, 32'd1, 32'd2, 1'b0, 1'b0, 16'd0, 16'd0, 1'b0, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_pass",  32'(pass2),    32'd0);
    checkOutput("mid_rst_fail",  32'(fail2),    32'd0);
    checkOutput("mid_rst_error", 32'(error2),   32'd0);
    checkOutput("mid_rst_ffidx", 32'(ffIndex2), 32'd0);
    checkOutput("mid_rst_ready", 32'(ready2),   32'd1);
    @(posedge clk);
    #1 rst_n = 1'b1;
    applyStimulus(OP_ADD, 32'd4, 32'd4, 32'd8, 1'b0, 1'b1, 16'd1, 16'd0, 1'b0, 1'b1);
    idle(4);
    checkOutput("post_rst_pass", 32'(pass2), 32'd1);

    checks++;
    if (sbQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL sb_drain: got %0d entries left, want 0", sbQ.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
